// File: rtl/spike_line_pingpong_buf.sv
// Ping-pong line buffer for spike images: a producer fills one bank line by
// line while a consumer reads complete frames from the other bank.

`ifndef IMG_WIDTH
`define IMG_WIDTH 4
`endif
`ifndef TIME_STEPS
`define TIME_STEPS 2
`endif

module spike_line_pingpong_buf #(
    parameter int unsigned IMG_W   = `IMG_WIDTH,
    parameter int unsigned T_STEPS = `TIME_STEPS,
    parameter int unsigned IMG_H   = 32,
    localparam int unsigned LW     = IMG_W * T_STEPS,
    localparam int unsigned AW     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic          s_clk,
    input  logic          s_rst,
    input  logic          i_line_valid,
    input  logic [LW-1:0] i_line_data,
    output logic          o_frame_ready,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_rd_valid,
    output logic [LW-1:0] o_rd_data,
    input  logic          i_frame_release,
    output logic [1:0]    o_full_cnt,
    output logic          o_overflow
);

    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 1);

    // Two banks of IMG_H lines; storage is intentionally not reset.
    logic [LW-1:0] mem [2][IMG_H];

    logic          wr_bank, wr_bank_nxt;
    logic [AW-1:0] wr_row,  wr_row_nxt;
    logic          rd_bank, rd_bank_nxt;
    logic [1:0]    full_cnt, full_cnt_nxt;
    logic          overflow_nxt;

    logic accept;
    logic last_row;
    logic frame_done;
    logic release_ok;
    logic rd_fire;

    // Qualify handshakes against the current occupancy.
    always_comb begin
        accept     = i_line_valid && (full_cnt != 2'd2);
        last_row   = (wr_row == LAST_ROW);
        frame_done = accept && last_row;
        release_ok = i_frame_release && (full_cnt != 2'd0);
        rd_fire    = i_rd_en && (full_cnt != 2'd0);
    end

    // Next-state for write/read pointers, occupancy and the sticky drop flag.
    always_comb begin
        wr_bank_nxt  = wr_bank;
        wr_row_nxt   = wr_row;
        rd_bank_nxt  = rd_bank;
        full_cnt_nxt = full_cnt;
        overflow_nxt = o_overflow | (i_line_valid & ~accept);

        if (accept) begin
            if (last_row) begin
                wr_row_nxt  = '0;
                wr_bank_nxt = ~wr_bank;
            end else begin
                wr_row_nxt  = wr_row + AW'(1);
            end
        end

        if (release_ok) begin
            rd_bank_nxt = ~rd_bank;
        end

        // A frame finishing while one is released leaves occupancy unchanged.
        case ({frame_done, release_ok})
            2'b10:   full_cnt_nxt = full_cnt + 2'd1;
            2'b01:   full_cnt_nxt = full_cnt - 2'd1;
            default: full_cnt_nxt = full_cnt;
        endcase
    end

    // Control state and read port registers.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            wr_bank    <= 1'b0;
            wr_row     <= '0;
            rd_bank    <= 1'b0;
            full_cnt   <= 2'd0;
            o_overflow <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            wr_bank    <= wr_bank_nxt;
            wr_row     <= wr_row_nxt;
            rd_bank    <= rd_bank_nxt;
            full_cnt   <= full_cnt_nxt;
            o_overflow <= overflow_nxt;
            o_rd_valid <= rd_fire;
            if (rd_fire) begin
                o_rd_data <= mem[rd_bank][i_rd_addr];
            end
        end
    end

    // Line storage write; only accepted lines land in the write bank.
    always_ff @(posedge s_clk) begin
        if (accept) begin
            mem[wr_bank][wr_row] <= i_line_data;
        end
    end

    // Status views of the occupancy counter.
    always_comb begin
        o_frame_ready = (full_cnt != 2'd0);
        o_full_cnt    = full_cnt;
    end

endmodule

// File: tb/tb_spike_line_pingpong_buf.sv
// Directed bench for spike_line_pingpong_buf with IMG_H=4, IMG_W=4, T_STEPS=2.

module tb_spike_line_pingpong_buf;

    logic       s_clk = 1'b0;
    logic       s_rst = 1'b1;
    logic       i_line_valid = 1'b0;
    logic [7:0] i_line_data = 8'h00;
    logic       o_frame_ready;
    logic       i_rd_en = 1'b0;
    logic [1:0] i_rd_addr = 2'd0;
    logic       o_rd_valid;
    logic [7:0] o_rd_data;
    logic       i_frame_release = 1'b0;
    logic [1:0] o_full_cnt;
    logic       o_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    spike_line_pingpong_buf #(
        .IMG_W   (4),
        .T_STEPS (2),
        .IMG_H   (4)
    ) dut (
        .s_clk           (s_clk),
        .s_rst           (s_rst),
        .i_line_valid    (i_line_valid),
        .i_line_data     (i_line_data),
        .o_frame_ready   (o_frame_ready),
        .i_rd_en         (i_rd_en),
        .i_rd_addr       (i_rd_addr),
        .o_rd_valid      (o_rd_valid),
        .o_rd_data       (o_rd_data),
        .i_frame_release (i_frame_release),
        .o_full_cnt      (o_full_cnt),
        .o_overflow      (o_overflow)
    );

    always #5 s_clk = ~s_clk;

    typedef struct packed {
        logic       rst;
        logic       lv;
        logic [7:0] ld;
        logic       re;
        logic [1:0] ra;
        logic       rel;
        logic       fr;
        logic [1:0] fc;
        logic       ov;
        logic       rv;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic lv, input logic [7:0] ld,
                                input logic re, input logic [1:0] ra, input logic rel,
                                input logic fr, input logic [1:0] fc, input logic ov,
                                input logic rv, input logic [7:0] rd);
        vec_t v;
        v.rst = rst; v.lv = lv; v.ld = ld; v.re = re; v.ra = ra; v.rel = rel;
        v.fr = fr; v.fc = fc; v.ov = ov; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic lv, input logic [7:0] ld,
                         input logic re, input logic [1:0] ra, input logic rel);
        @(negedge s_clk);
        s_rst           = rst;
        i_line_valid    = lv;
        i_line_data     = ld;
        i_rd_en         = re;
        i_rd_addr       = ra;
        i_frame_release = rel;
        @(posedge s_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic fr, input logic [1:0] fc,
                           input logic ov, input logic rv, input logic [7:0] rd);
        chk({tag, " frame_ready"}, 32'(o_frame_ready), 32'(fr));
        chk({tag, " full_cnt"},    32'(o_full_cnt),    32'(fc));
        chk({tag, " overflow"},    32'(o_overflow),    32'(ov));
        chk({tag, " rd_valid"},    32'(o_rd_valid),    32'(rv));
        chk({tag, " rd_data"},     32'(o_rd_data),     32'(rd));
    endtask

    initial begin
        // rst lv  ld    re ra   rel   fr fc   ov rv rd
        // release / read while empty
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b0,2'd0,1'b1, 1'b0,2'd0,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0,8'h00));
        // frame 0 into bank 0, read addr 2
        vecs.push_back(mk(1'b0,1'b1,8'h11, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b1,8'h22, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b1,8'h33, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b1,8'h44, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd2,1'b0, 1'b1,2'd1,1'b0,1'b1,8'h33));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b0,1'b0,8'h33));
        // frame 1 into bank 1, then a dropped 9th line
        vecs.push_back(mk(1'b0,1'b1,8'h55, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b0,1'b0,8'h33));
        vecs.push_back(mk(1'b0,1'b1,8'h66, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b0,1'b0,8'h33));
        vecs.push_back(mk(1'b0,1'b1,8'h77, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b0,1'b0,8'h33));
        vecs.push_back(mk(1'b0,1'b1,8'h88, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b0,1'b0,8'h33));
        vecs.push_back(mk(1'b0,1'b1,8'h99, 1'b0,2'd0,1'b0, 1'b1,2'd2,1'b1,1'b0,8'h33));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd0,1'b0, 1'b1,2'd2,1'b1,1'b1,8'h11));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd3,1'b0, 1'b1,2'd2,1'b1,1'b1,8'h44));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b0,2'd0,1'b1, 1'b1,2'd1,1'b1,1'b0,8'h44));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b1,8'h55));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b0,2'd0,1'b1, 1'b0,2'd0,1'b1,1'b0,8'h55));
        // frame a into bank 0, frame b into bank 1 completing with a release
        vecs.push_back(mk(1'b0,1'b1,8'ha1, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0,8'h55));
        vecs.push_back(mk(1'b0,1'b1,8'ha2, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0,8'h55));
        vecs.push_back(mk(1'b0,1'b1,8'ha3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0,8'h55));
        vecs.push_back(mk(1'b0,1'b1,8'ha4, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0,8'h55));
        vecs.push_back(mk(1'b0,1'b1,8'hb1, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0,8'h55));
        vecs.push_back(mk(1'b0,1'b1,8'hb2, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0,8'h55));
        vecs.push_back(mk(1'b0,1'b1,8'hb3, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b0,8'h55));
        vecs.push_back(mk(1'b0,1'b1,8'hb4, 1'b0,2'd0,1'b1, 1'b1,2'd1,1'b1,1'b0,8'h55));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd0,1'b0, 1'b1,2'd1,1'b1,1'b1,8'hb1));
        // read and release together: data comes from the pre-toggle bank
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd3,1'b1, 1'b0,2'd0,1'b1,1'b1,8'hb4));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0,8'hb4));
        // reset after two lines, then a fresh frame in bank 0
        vecs.push_back(mk(1'b0,1'b1,8'hc1, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0,8'hb4));
        vecs.push_back(mk(1'b0,1'b1,8'hc2, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b1,1'b0,8'hb4));
        vecs.push_back(mk(1'b1,1'b0,8'h00, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b1,8'hd1, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b1,8'hd2, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b1,8'hd3, 1'b0,2'd0,1'b0, 1'b0,2'd0,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b1,8'hd4, 1'b0,2'd0,1'b0, 1'b1,2'd1,1'b0,1'b0,8'h00));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd0,1'b0, 1'b1,2'd1,1'b0,1'b1,8'hd1));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b1,2'd3,1'b0, 1'b1,2'd1,1'b0,1'b1,8'hd4));
        vecs.push_back(mk(1'b0,1'b0,8'h00, 1'b0,2'd0,1'b1, 1'b0,2'd0,1'b0,1'b0,8'hd4));

        // Reset state
        repeat (2) @(posedge s_clk);
        #1;
        chk_all("reset", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].lv, vecs[i].ld, vecs[i].re, vecs[i].ra, vecs[i].rel);
            chk_all($sformatf("v%0d", i), vecs[i].fr, vecs[i].fc, vecs[i].ov, vecs[i].rv, vecs[i].rd);
        end

        // Stream of three frames, each read back in order then released
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 4; r++) begin
                drive(1'b0, 1'b1, 8'((f + 1) * 16 + r), 1'b0, 2'd0, 1'b0);
            end
            chk($sformatf("stream f%0d full_cnt", f), 32'(o_full_cnt), 32'd1);
            for (int r = 0; r < 4; r++) begin
                drive(1'b0, 1'b0, 8'h00, 1'b1, 2'(r), 1'b0);
                chk($sformatf("stream f%0d r%0d rd_valid", f, r), 32'(o_rd_valid), 32'd1);
                chk($sformatf("stream f%0d r%0d rd_data", f, r), 32'(o_rd_data),
                    32'((f + 1) * 16 + r));
            end
            drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
            chk($sformatf("stream f%0d released", f), 32'(o_full_cnt), 32'd0);
        end
        chk("stream overflow", 32'(o_overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Reset release at a falling edge before the table starts
    initial begin
        @(negedge s_clk);
        @(negedge s_clk);
        @(negedge s_clk);
        s_rst = 1'b0;
    end

endmodule

// File: doc/spike_line_pingpong_buf.md
SPIKE_LINE_PINGPONG_BUF -- requirements
Module: spike_line_pingpong_buf

Interface
REQ-001 SHALL have parameter IMG_W, default `IMG_WIDTH, meaning pixels per spike line.
REQ-002 SHALL have parameter T_STEPS, default `TIME_STEPS, meaning spike bits per pixel.
REQ-003 SHALL have parameter IMG_H, default 32, meaning lines per frame.
REQ-004 SHALL have derived constants LW = IMG_W*T_STEPS and AW = clog2(IMG_H); neither is a port.
REQ-005 SHALL have port s_clk, input, 1, clock, all logic rising-edge.
REQ-006 SHALL have port s_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port i_line_valid, input, 1, one-cycle strobe: i_line_data holds a complete line.
REQ-008 SHALL have port i_line_data, input, LW, spike line; pixel 0 in bits [T_STEPS-1:0].
REQ-009 SHALL have port o_frame_ready, output, 1, at least one complete frame is buffered.
REQ-010 SHALL have port i_rd_en, input, 1, read request for the current read bank.
REQ-011 SHALL have port i_rd_addr, input, AW, line index to read.
REQ-012 SHALL have port o_rd_valid, output, 1, o_rd_data valid this cycle.
REQ-013 SHALL have port o_rd_data, output, LW, line read from the read bank.
REQ-014 SHALL have port i_frame_release, input, 1, one-cycle pulse: consumer finished the read bank.
REQ-015 SHALL have port o_full_cnt, output, 2, number of complete buffered frames (0..2).
REQ-016 SHALL have port o_overflow, output, 1, sticky flag: a line was dropped.

Function
REQ-017 SHALL contain two banks, each of IMG_H x LW bits, with no reset on the storage.
REQ-018 SHALL keep wr_bank (1b), wr_row (AW), rd_bank (1b) and full_cnt (0..2).
REQ-019 SHALL accept a line only when i_line_valid=1 and full_cnt<2: write the line to bank[wr_bank][wr_row] that same cycle.
REQ-020 SHALL increment wr_row on each accepted line; at wr_row=IMG_H-1 SHALL wrap wr_row to 0, toggle wr_bank and increment full_cnt.
REQ-021 SHALL drop a line that arrives with full_cnt=2: no write, no pointer change, o_overflow set to 1 the next cycle.
REQ-022 SHALL hold o_overflow at 1 until reset.
REQ-023 SHALL drive o_frame_ready = (full_cnt != 0) combinationally, and o_full_cnt = full_cnt.
REQ-024 SHALL serve reads: i_rd_en=1 with o_frame_ready=1 gives o_rd_data = bank[rd_bank][i_rd_addr] and o_rd_valid=1 exactly one cycle later.
REQ-025 SHALL ignore i_rd_en while o_frame_ready=0: o_rd_valid=0 next cycle and o_rd_data held.
REQ-026 SHALL hold o_rd_data when o_rd_valid=0.
REQ-027 SHALL handle i_frame_release with full_cnt>0 by toggling rd_bank and decrementing full_cnt; with full_cnt=0 it is ignored.
REQ-028 SHALL, when frame completion (REQ-020) and a valid release occur in the same cycle, leave full_cnt unchanged while toggling both wr_bank and rd_bank.
REQ-029 SHALL, when i_rd_en and i_frame_release coincide, return the read from the bank before the toggle.
REQ-030 SHALL use i_rd_addr >= IMG_H as don't-care; a read there SHALL NOT disturb any state.
REQ-031 SHALL never write to bank rd_bank while full_cnt>0 and wr_bank==rd_bank; this is guaranteed by REQ-019.

Reset
REQ-032 SHALL, on s_rst=1, immediately clear wr_bank, wr_row, rd_bank, full_cnt, o_overflow, o_rd_valid and o_rd_data to 0.
REQ-033 SHALL discard any partially written frame on reset mid-frame; the next accepted line goes to bank 0, row 0.
REQ-034 SHALL accept the first line on the first rising edge after s_rst deasserts.

Verification (IMG_H=4, IMG_W=4, T_STEPS=2, LW=8)
REQ-035 Four lines 8'h11, 8'h22, 8'h33, 8'h44 -> o_frame_ready=1 after the 4th line; reading addr 2 gives o_rd_data=8'h33 with o_rd_valid one cycle after i_rd_en.
REQ-036 Eight lines with no release -> o_full_cnt=2; a 9th line -> dropped, o_overflow=1 and sticky; rows of bank 0 unchanged.
REQ-037 Release pulse at o_full_cnt=0 -> no change; i_rd_en at o_full_cnt=0 -> o_rd_valid stays 0.
REQ-038 o_full_cnt=1 with the 4th line of frame 2 arriving in the same cycle as i_frame_release -> o_full_cnt stays 1, rd_bank=1, and reading addr 0 returns frame 2 line 0.
REQ-039 Reset asserted after 2 lines -> all outputs 0; the next 4 lines form a frame in bank 0 and o_frame_ready=1.
REQ-040 Continuous stream of 12 lines with a release after each completed frame -> no overflow, and the read data matches the input order frame by frame.
